// File: rtl/sprinkler_zone_sequencer.sv
// -----------------------------------------------------------------------------
// sprinkler_zone_sequencer
//
// Timed sequencer feeding a 3-to-8 valve decoder (inputs e, a, b, c). Walks
// zones 0..7 in ascending order. Each zone enabled in the latched mask is
// opened for `duration` time-base ticks. The valve is then closed for
// GAP_TICKS ticks before the walk moves on to the next zone.
//
// Optional feature macro: RAIN_SENSE_EN
//   When defined, a synchronous `rain` input pauses watering. The valve closes
//   and the remaining time is frozen until rain clears.
//
// Parameters:
//   DUR_W      width of the watering duration / timer (ticks)
//   GAP_TICKS  dead-time ticks between zones with e=0 (>= 1)
//
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   tick       one-cycle time-base strobe; every timing count is in ticks
//   start      pulse; starts a cycle when idle (ignored while busy)
//   stop       pulse; aborts at the next edge (priority over start/tick)
//   zone_mask  per-zone enable, latched at start
//   duration   ticks per zone, latched at start
//   rain       (RAIN_SENSE_EN only) pause watering while high
//   e          decoder enable, high only while a valve is open
//   a, b, c    zone index, a = MSB, c = LSB
//   busy       high in any state other than IDLE
//   done       one-cycle pulse on normal completion
//   state_o    current FSM state (debug observation)
// -----------------------------------------------------------------------------
module sprinkler_zone_sequencer #(
  parameter int DUR_W     = 8,
  parameter int GAP_TICKS = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick,
  input  logic             start,
  input  logic             stop,
  input  logic [7:0]       zone_mask,
  input  logic [DUR_W-1:0] duration,
`ifdef RAIN_SENSE_EN
  input  logic             rain,
`endif
  output logic             e,
  output logic             a,
  output logic             b,
  output logic             c,
  output logic             busy,
  output logic             done,
  output logic [1:0]       state_o
);

  localparam int GAP_W = $clog2(GAP_TICKS + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SEEK  = 2'd1,
    S_WATER = 2'd2,
    S_GAP   = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [7:0]         mask_q, mask_d;
  logic [DUR_W-1:0]   dur_q, dur_d;
  logic [DUR_W-1:0]   timer_q, timer_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic [2:0]         idx_q, idx_d;
  logic               e_q, e_d;
  logic               done_q, done_d;
  logic               rain_w;

`ifdef RAIN_SENSE_EN
  assign rain_w = rain;
`else
  assign rain_w = 1'b0;
`endif

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    dur_d   = dur_q;
    timer_d = timer_q;
    gap_d   = gap_q;
    idx_d   = idx_q;
    e_d     = e_q;
    done_d  = 1'b0;

    if (stop) begin
      // Abort wins over everything: valve shut, index parked at zone 0.
      state_d = S_IDLE;
      e_d     = 1'b0;
      idx_d   = 3'd0;
      timer_d = '0;
      gap_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          e_d = 1'b0;
          if (start) begin
            mask_d  = zone_mask;
            dur_d   = duration;
            idx_d   = 3'd0;
            state_d = S_SEEK;
          end
        end

        S_SEEK: begin
          // One zone examined per clock; ticks are not consumed here.
          if (mask_q[idx_q] && (dur_q != '0)) begin
            state_d = S_WATER;
            timer_d = dur_q;
            e_d     = 1'b1;
          end else if (idx_q == 3'd7) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end

        S_WATER: begin
          // Rain closes the valve and freezes the timer; the valve reopens
          // one clock after rain clears.
          e_d = ~rain_w;
          if (tick && !rain_w) begin
            if (timer_q != '0) begin
              timer_d = timer_q - DUR_W'(1);
            end
            if (timer_q == DUR_W'(1)) begin
              e_d     = 1'b0;
              gap_d   = GAP_W'(GAP_TICKS);
              state_d = S_GAP;
            end
          end
        end

        S_GAP: begin
          // Index still shows the last zone; it only moves with e low.
          e_d = 1'b0;
          if (tick) begin
            if (gap_q != '0) begin
              gap_d = gap_q - GAP_W'(1);
            end
            if (gap_q == GAP_W'(1)) begin
              if (idx_q == 3'd7) begin
                state_d = S_IDLE;
                done_d  = 1'b1;
              end else begin
                idx_d   = idx_q + 3'd1;
                state_d = S_SEEK;
              end
            end
          end
        end

        default: begin
          state_d = S_IDLE;
          e_d     = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      mask_q  <= '0;
      dur_q   <= '0;
      timer_q <= '0;
      gap_q   <= '0;
      idx_q   <= 3'd0;
      e_q     <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      dur_q   <= dur_d;
      timer_q <= timer_d;
      gap_q   <= gap_d;
      idx_q   <= idx_d;
      e_q     <= e_d;
      done_q  <= done_d;
    end
  end

  // Enable comes straight from a flop so the decoder never sees a glitch.
  // With rain sensing, the synchronous rain level also masks it. The valve
  // then shuts in the same cycle rain rises.
  assign e       = e_q & ~rain_w;
  assign {a, b, c} = idx_q;
  assign busy    = (state_q != S_IDLE);
  assign done    = done_q;
  assign state_o = state_q;

endmodule

// File: doc/sprinkler_zone_sequencer.md
Name: sprinkler_zone_sequencer

Overview:
Timed sequencer that drives the 3-to-8 valve decoder's inputs (e, a, b, c). It walks zones 0..7 in ascending order, opens each enabled zone for a programmed number of time-base ticks, and closes the valve for a dead-time gap before moving to the next zone. It sits directly upstream of the decoder. The decoder's one-hot outputs drive the valve solenoids.

Parameters:
DUR_W, 8, width of the watering-duration count in ticks
GAP_TICKS, 2, dead-time ticks with e=0 between consecutive zones (>=1)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
tick  input  1  one-cycle time-base pulse (e.g. 1 Hz strobe); all timing counts tick pulses
start  input  1  pulse; begins a watering cycle when idle
stop  input  1  pulse; aborts the cycle immediately
zone_mask  input  8  bit n=1 enables zone n; latched at start
duration  input  DUR_W  watering ticks per zone; latched at start
e  output  1  decoder enable; 1 only while a valve is open
a  output  1  zone index bit 2 (MSB)
b  output  1  zone index bit 1
c  output  1  zone index bit 0 (LSB)
busy  output  1  1 in any state other than IDLE
done  output  1  one-cycle pulse when a cycle completes normally

Behaviour:
- Reset (async, rst_n=0): state=IDLE; e=0; {a,b,c}=000; busy=0; done=0; internal mask, duration, timer, and zone index cleared.
- States: IDLE, SEEK, WATER, GAP.
- IDLE: on start=1, latch zone_mask and duration, set zone index=0, and go to SEEK on the next clock. busy rises that edge.
- SEEK: examines one zone per clock.
  - If mask[idx]=1 and latched duration!=0: go to WATER, load timer=duration, and set e=1 with {a,b,c}=idx on the same edge.
  - Otherwise, if idx=7: go to IDLE with done=1 for one cycle.
  - Otherwise: idx=idx+1 and stay in SEEK.
- WATER: e=1 and {a,b,c}=idx held stable. On each tick, timer decrements. On the tick where timer=1: e=0, load gap counter=GAP_TICKS, go to GAP. The valve is open for exactly `duration` tick pulses.
- GAP: e=0 and {a,b,c} holds the last zone. On each tick, the gap counter decrements. On the tick where it is 1:
  - if idx=7: go to IDLE with a done pulse;
  - else: idx=idx+1 and go to SEEK.
- {a,b,c} changes only while e=0. No two zones are ever open, and no glitch reaches the decoder.
- Ticks arriving during IDLE or SEEK are ignored.
- stop=1 in any state: next edge forces IDLE, e=0, {a,b,c}=000, no done pulse. stop has priority over start and tick in the same cycle.
- start while busy: ignored. Latched mask and duration are unaffected by input changes mid-cycle.
- zone_mask=8'h00 or duration=0: SEEK scans all 8 zones (8 clocks), then done. e never asserts.
- Asynchronous reset mid-cycle: e drops immediately (asynchronously) to 0.
- Timer is DUR_W bits with no wrap. It is loaded only in SEEK and decremented only when nonzero.

Optional Feature:
RAIN_SENSE_EN:
- When defined, adds input rain (1 bit, synchronous level).
- While rain=1 in WATER: e is forced to 0, ticks do not decrement the timer, and the state stays WATER.
- When rain returns to 0: e re-asserts on the next clock and the remaining time resumes.
- rain has no effect in other states.
- stop still aborts while raining.
- When not defined: no rain port, and WATER behaves as specified above.

Test Plan:
- Reset then idle: rst_n low mid-WATER -> e=0 immediately; after release, busy=0 and {a,b,c}=000.
- mask=8'b0000_0101, duration=3, GAP_TICKS=2, start:
  - e=1, abc=000 for 3 ticks;
  - e=0 for 2 ticks;
  - e=1, abc=010 for 3 ticks;
  - 2 gap ticks, then done pulse, busy=0.
- mask=8'h80, duration=1: SEEK takes 8 clocks, then e=1 with abc=111 for 1 tick, then 2 gap ticks, then done.
- mask=8'h00 (or duration=0): done pulses 9 clocks after start; e never 1.
- stop asserted in WATER of zone 2 with start in the same cycle -> IDLE next clock, e=0, abc=000, no done, no restart.
- RAIN_SENSE_EN: rain=1 after 1 of 4 ticks in zone 0 for 5 ticks -> e=0 throughout the rain. After rain=0, e=1 for exactly 3 more ticks.
